// File: rtl/dsha_job_scheduler.sv
// dsha_job_scheduler: nonce sequencer and share filter for the double-SHA256 finisher.
// Ports: job_* job offer in, abort, fin_* finisher drive and results in,
//        result_* hit FIFO out, busy/job_done/overflow/hash_count status out.
`timescale 1ns/1ps
module dsha_job_scheduler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PIPE_SKIP  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_midstate,
    input  logic [95:0]  job_tail,
    input  logic [31:0]  job_nonce_start,
    input  logic [31:0]  job_nonce_end,
    input  logic [31:0]  job_target,
    input  logic         abort,
    output logic [255:0] fin_X,
    output logic [95:0]  fin_Y,
    output logic [31:0]  fin_nonce,
    input  logic         fin_accepted,
    input  logic [255:0] fin_hash,
    input  logic [31:0]  fin_out_nonce,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [31:0]  result_nonce,
    output logic [31:0]  result_word,
    output logic         busy,
    output logic         job_done,
    output logic         overflow,
    output logic [31:0]  hash_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned SW = (PIPE_SKIP > 0) ? $clog2(PIPE_SKIP + 1) : 1;
    localparam logic [SW-1:0] SKIP_INIT = SW'(PIPE_SKIP);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [255:0]   mid_q, mid_d;
    logic [95:0]    tail_q, tail_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [31:0]    end_q, end_d;
    logic [31:0]    tgt_q, tgt_d;
    logic [SW-1:0]  skip_q, skip_d;
    logic [1:0]     drain_q, drain_d;
    logic           eval_q, eval_d;
    logic           ovf_q, ovf_d;
    logic [31:0]    cnt_q, cnt_d;

    logic [63:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [AW:0]    fcnt_q, fcnt_d;

    logic        job_take;
    logic        acc_live;
    logic        last_nonce;
    logic        eval_fire;
    logic [31:0] w;
    logic        hit;
    logic        full;
    logic        pop;
    logic        push_ok;
    logic        unused_hash;

    // Top hash word as the host compares it: bytes of fin_hash[255:224] reversed.
    assign w = {fin_hash[231:224], fin_hash[239:232],
                fin_hash[247:240], fin_hash[255:248]};
    assign unused_hash = ^fin_hash[223:0];

    assign last_nonce = (nonce_q == end_q);
    assign job_take   = job_valid && job_ready && !abort;
    // Acceptances only count while a job is issuing or its tail is draining.
    assign acc_live   = fin_accepted && !abort &&
                        ((state_q == S_RUN) ||
                         ((state_q == S_DRAIN) && (drain_q != 2'd0)));
    assign eval_fire  = eval_q && !abort;
    assign hit        = (w <= tgt_q);

    assign full    = (fcnt_q == FULL_CNT);
    assign pop     = result_valid && result_ready;
    assign push_ok = eval_fire && hit && (!full || pop);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DRAIN leaves once the last evaluation is in flight.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (job_take) state_d = S_RUN;
            S_RUN:   if (fin_accepted && last_nonce) state_d = S_DRAIN;
            S_DRAIN: if (drain_q == 2'd0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Output decode
    always_comb begin
        job_ready = 1'b0;
        busy      = 1'b0;
        job_done  = 1'b0;
        unique case (state_q)
            S_IDLE:         job_ready = 1'b1;
            S_RUN, S_DRAIN: busy      = 1'b1;
            S_DONE:         job_done  = 1'b1;
            default:        job_ready = 1'b0;
        endcase
    end

    // Job registers, nonce stepping, result qualification and counters
    always_comb begin
        mid_d   = mid_q;
        tail_d  = tail_q;
        nonce_d = nonce_q;
        end_d   = end_q;
        tgt_d   = tgt_q;
        skip_d  = skip_q;
        drain_d = drain_q;
        eval_d  = 1'b0;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (acc_live) begin
            // The first results after a job start belong to the previous job.
            if (skip_q != '0) skip_d = skip_q - SW'(1);
            else              eval_d = 1'b1;
            if (state_q == S_RUN) begin
                if (last_nonce) drain_d = 2'd2;
                else            nonce_d = nonce_q + 32'd1;
            end else begin
                drain_d = drain_q - 2'd1;
            end
        end
        if (eval_fire) begin
            if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
            if (hit && !push_ok) ovf_d = 1'b1;
        end
        if (job_take) begin
            mid_d   = job_midstate;
            tail_d  = job_tail;
            nonce_d = job_nonce_start;
            end_d   = job_nonce_end;
            tgt_d   = job_target;
            skip_d  = SKIP_INIT;
            drain_d = 2'd0;
            ovf_d   = 1'b0;
            cnt_d   = 32'd0;
        end
        if (abort) eval_d = 1'b0;
    end

    // FIFO pointers; a pop frees the slot a same-cycle push lands in.
    always_comb begin
        wr_d   = push_ok ? wr_q + AW'(1) : wr_q;
        rd_d   = pop ? rd_q + AW'(1) : rd_q;
        fcnt_d = fcnt_q;
        unique case ({push_ok, pop})
            2'b10:   fcnt_d = fcnt_q + (AW + 1)'(1);
            2'b01:   fcnt_d = fcnt_q - (AW + 1)'(1);
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_q   <= '0;
            tail_q  <= '0;
            nonce_q <= '0;
            end_q   <= '0;
            tgt_q   <= '0;
            skip_q  <= '0;
            drain_q <= '0;
            eval_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            fcnt_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mid_q   <= mid_d;
            tail_q  <= tail_d;
            nonce_q <= nonce_d;
            end_q   <= end_d;
            tgt_q   <= tgt_d;
            skip_q  <= skip_d;
            drain_q <= drain_d;
            eval_q  <= eval_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fcnt_q  <= fcnt_d;
            if (push_ok) mem_q[wr_q] <= {fin_out_nonce, w};
        end
    end

    assign fin_X        = mid_q;
    assign fin_Y        = tail_q;
    assign fin_nonce    = nonce_q;
    assign overflow     = ovf_q;
    assign hash_count   = cnt_q;
    assign result_valid = (fcnt_q != '0);
    assign result_nonce = mem_q[rd_q][63:32];
    assign result_word  = mem_q[rd_q][31:0];

endmodule

// File: tb/tb_dsha_job_scheduler.sv
// tb_dsha_job_scheduler: randomized self-checking bench for dsha_job_scheduler.
// A two-stage finisher model feeds results; a queue model predicts FIFO contents.
`timescale 1ns/1ps
module tb_dsha_job_scheduler;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         job_valid;
    logic         job_ready;
    logic [255:0] job_midstate;
    logic [95:0]  job_tail;
    logic [31:0]  job_nonce_start;
    logic [31:0]  job_nonce_end;
    logic [31:0]  job_target;
    logic         abort;
    logic [255:0] fin_X;
    logic [95:0]  fin_Y;
    logic [31:0]  fin_nonce;
    logic         fin_accepted;
    logic [255:0] fin_hash;
    logic [31:0]  fin_out_nonce;
    logic         result_valid;
    logic         result_ready;
    logic [31:0]  result_nonce;
    logic [31:0]  result_word;
    logic         busy;
    logic         job_done;
    logic         overflow;
    logic [31:0]  hash_count;

    always #5 clk = ~clk;

    dsha_job_scheduler #(.FIFO_DEPTH(DEPTH), .PIPE_SKIP(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_midstate(job_midstate), .job_tail(job_tail),
        .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
        .job_target(job_target), .abort(abort),
        .fin_X(fin_X), .fin_Y(fin_Y), .fin_nonce(fin_nonce),
        .fin_accepted(fin_accepted), .fin_hash(fin_hash),
        .fin_out_nonce(fin_out_nonce),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_nonce(result_nonce), .result_word(result_word),
        .busy(busy), .job_done(job_done), .overflow(overflow),
        .hash_count(hash_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int done_base = 0;
    logic [63:0] mq[$];
    bit ovf_exp = 1'b0;
    bit zero_mode = 1'b0;
    logic [31:0] wseed = 32'h0;
    logic [31:0] p0 = 32'h0;
    logic [31:0] p1 = 32'h0;

    always @(negedge clk) if (job_done === 1'b1) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Host-view top word of the hash the model finisher produces for nonce n.
    function automatic logic [31:0] w_of(input logic [31:0] n);
        logic [31:0] m;
        m = (n ^ wseed) * 32'h9E3779B1;
        m = m ^ (m >> 13);
        if (zero_mode) return (n == 32'h0) ? 32'h0 : (m | 32'h1);
        return m;
    endfunction

    task automatic set_out(input logic [31:0] n);
        logic [31:0]  wv;
        logic [255:0] h;
        wv = w_of(n);
        h = rnd256();
        h[255:224] = {wv[7:0], wv[15:8], wv[23:16], wv[31:24]};
        fin_out_nonce = n;
        fin_hash = h;
    endtask

    // One acceptance: results emerge two acceptances after their nonce.
    task automatic accept_edge();
        logic [31:0] n;
        @(negedge clk);
        n = fin_nonce;
        fin_accepted = 1'b1;
        @(posedge clk);
        #1;
        fin_accepted = 1'b0;
        set_out(p1);
        p1 = p0;
        p0 = n;
    endtask

    task automatic accepts(input int k);
        for (int i = 0; i < k; i++) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            accept_edge();
        end
    endtask

    task automatic queue_hits(input logic [31:0] s, input int n,
                              input logic [31:0] t);
        logic [31:0] nn;
        for (int i = 0; i < n; i++) begin
            nn = s + 32'(i);
            if (w_of(nn) <= t) begin
                if (mq.size() < DEPTH) mq.push_back({nn, w_of(nn)});
                else ovf_exp = 1'b1;
            end
        end
    endtask

    task automatic start_job(input logic [31:0] s, input logic [31:0] e,
                             input logic [31:0] t, input string tag);
        logic [255:0] m;
        logic [95:0]  tl;
        m = rnd256();
        tl = {$urandom, $urandom, $urandom};
        @(negedge clk);
        n_cmp++;
        if (job_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s job_ready: got %b want 1", tag, job_ready);
        end
        job_valid = 1'b1;
        job_midstate = m;
        job_tail = tl;
        job_nonce_start = s;
        job_nonce_end = e;
        job_target = t;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        done_base = done_cnt;
        ovf_exp = 1'b0;
        n_cmp++;
        if (fin_nonce !== s || fin_X !== m || fin_Y !== tl || busy !== 1'b1 ||
            overflow !== 1'b0 || hash_count !== 32'h0) begin
            n_bad++;
            $display("FAIL %s accept: got nonce=%h busy=%b ovf=%b cnt=%h X=%h Y=%h want nonce=%h busy=1 ovf=0 cnt=0 X=%h Y=%h",
                     tag, fin_nonce, busy, overflow, hash_count, fin_X, fin_Y,
                     s, m, tl);
        end
    endtask

    task automatic finish_job(input logic [31:0] exp_cnt, input string tag);
        int waited;
        waited = 0;
        while (job_ready !== 1'b1 && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (job_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s idle_timeout: got job_ready=%b want 1", tag, job_ready);
        end
        n_cmp++;
        if (done_cnt !== done_base + 1) begin
            n_bad++;
            $display("FAIL %s job_done: got %0d pulses want 1", tag, done_cnt - done_base);
        end
        n_cmp++;
        if (hash_count !== exp_cnt) begin
            n_bad++;
            $display("FAIL %s hash_count: got %h want %h", tag, hash_count, exp_cnt);
        end
        n_cmp++;
        if (overflow !== ovf_exp || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s status: got ovf=%b busy=%b want ovf=%b busy=0",
                     tag, overflow, busy, ovf_exp);
        end
    endtask

    task automatic drain_check(input string tag);
        logic [63:0] exp;
        while (mq.size() > 0) begin
            @(negedge clk);
            exp = mq.pop_front();
            n_cmp++;
            if (result_valid !== 1'b1 || {result_nonce, result_word} !== exp) begin
                n_bad++;
                $display("FAIL %s fifo_entry: got v=%b %h_%h want v=1 %h_%h", tag,
                         result_valid, result_nonce, result_word, exp[63:32], exp[31:0]);
            end
            result_ready = 1'b1;
            @(posedge clk);
            #1;
            result_ready = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s fifo_empty: got result_valid=%b want 0", tag, result_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        job_valid = 1'b0;
        job_midstate = '0;
        job_tail = '0;
        job_nonce_start = '0;
        job_nonce_end = '0;
        job_target = '0;
        abort = 1'b0;
        fin_accepted = 1'b0;
        fin_hash = '0;
        fin_out_nonce = '0;
        result_ready = 1'b0;
        #3;
        n_cmp++;
        if (job_ready !== 1'b1 || busy !== 1'b0 || job_done !== 1'b0 ||
            overflow !== 1'b0 || hash_count !== 32'h0 || result_valid !== 1'b0 ||
            fin_nonce !== 32'h0 || fin_X !== '0 || fin_Y !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got rdy=%b busy=%b done=%b ovf=%b cnt=%h rv=%b nonce=%h want 1 0 0 0 0 0 0",
                     job_ready, busy, job_done, overflow, hash_count,
                     result_valid, fin_nonce);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        zero_mode = 1'b0;
        wseed = $urandom;
        start_job(32'd5, 32'd7, 32'hFFFFFFFF, "basic");
        queue_hits(32'd5, 3, 32'hFFFFFFFF);
        accepts(4);
        n_cmp++;
        if (done_cnt !== done_base) begin
            n_bad++;
            $display("FAIL basic early_done: got %0d pulses want 0", done_cnt - done_base);
        end
        accepts(1);
        finish_job(32'd3, "basic");
        drain_check("basic");
    endtask

    task automatic test_wrap();
        zero_mode = 1'b1;
        wseed = $urandom;
        start_job(32'hFFFFFFFE, 32'h00000001, 32'h0, "wrap");
        queue_hits(32'hFFFFFFFE, 4, 32'h0);
        accepts(6);
        finish_job(32'd4, "wrap");
        n_cmp++;
        if (mq.size() !== 1 || mq[0] !== 64'h0) begin
            n_bad++;
            $display("FAIL wrap model: got %0d entries want 1 zero entry", mq.size());
        end
        drain_check("wrap");
        zero_mode = 1'b0;
    endtask

    task automatic test_random_jobs();
        logic [31:0] s;
        logic [31:0] t;
        int n;
        for (int j = 0; j < 6; j++) begin
            wseed = $urandom;
            n = $urandom_range(1, 7);
            if ($urandom_range(0, 2) == 0) s = 32'hFFFFFFFF - 32'($urandom_range(0, 4));
            else s = $urandom;
            t = $urandom;
            start_job(s, s + 32'(n - 1), t, "random");
            queue_hits(s, n, t);
            accepts(n + 2);
            finish_job(32'(n), "random");
            drain_check("random");
        end
    endtask

    task automatic test_overflow();
        wseed = $urandom;
        start_job(32'h1000, 32'h1005, 32'hFFFFFFFF, "overflow");
        queue_hits(32'h1000, 6, 32'hFFFFFFFF);
        accepts(8);
        finish_job(32'd6, "overflow");
    endtask

    task automatic test_pop_full();
        logic [31:0] s;
        s = 32'h2000;
        start_job(s, s, 32'hFFFFFFFF, "pop_full");
        accepts(3);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        void'(mq.pop_front());
        mq.push_back({s, w_of(s)});
        finish_job(32'd1, "pop_full");
        drain_check("pop_full");
    endtask

    task automatic test_abort();
        logic [31:0] s;
        logic [31:0] s2;
        logic [31:0] t2;
        s = $urandom;
        wseed = $urandom;
        start_job(s, s + 32'd99, 32'hFFFFFFFF, "abort");
        queue_hits(s, 1, 32'hFFFFFFFF);
        accepts(3);
        n_cmp++;
        if (fin_nonce !== s + 32'd3) begin
            n_bad++;
            $display("FAIL abort nonce_step: got %h want %h", fin_nonce, s + 32'd3);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        n_cmp++;
        if (job_ready !== 1'b1 || busy !== 1'b0 || hash_count !== 32'd1) begin
            n_bad++;
            $display("FAIL abort idle: got rdy=%b busy=%b cnt=%h want 1 0 1",
                     job_ready, busy, hash_count);
        end
        n_cmp++;
        if (done_cnt !== done_base) begin
            n_bad++;
            $display("FAIL abort no_done: got %0d pulses want 0", done_cnt - done_base);
        end
        s2 = $urandom;
        t2 = $urandom;
        start_job(s2, s2 + 32'd1, t2, "after_abort");
        queue_hits(s2, 2, t2);
        accepts(4);
        finish_job(32'd2, "after_abort");
        drain_check("after_abort");
    endtask

    task automatic test_reset_mid_run();
        wseed = $urandom;
        start_job(32'h100, 32'h109, 32'hFFFFFFFF, "rst_run");
        accepts(4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (result_valid !== 1'b1 || hash_count !== 32'd2 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_run pre: got rv=%b cnt=%h busy=%b want 1 2 1",
                     result_valid, hash_count, busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (job_ready !== 1'b1 || busy !== 1'b0 || job_done !== 1'b0 ||
            overflow !== 1'b0 || hash_count !== 32'h0 || result_valid !== 1'b0 ||
            fin_nonce !== 32'h0 || fin_X !== '0 || fin_Y !== '0) begin
            n_bad++;
            $display("FAIL rst_run async: got rdy=%b busy=%b done=%b ovf=%b cnt=%h rv=%b nonce=%h want 1 0 0 0 0 0 0",
                     job_ready, busy, job_done, overflow, hash_count,
                     result_valid, fin_nonce);
        end
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (result_valid !== 1'b0 || job_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_run release: got rv=%b rdy=%b want 0 1",
                     result_valid, job_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_random_jobs();
        test_overflow();
        test_pop_full();
        test_abort();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dsha_job_scheduler.md
Name: dsha_job_scheduler

Overview:
Work controller that sequences the double-SHA256 finisher for mining. It accepts a job (midstate, 96-bit header tail, nonce range, share target) and steps the nonce once per finisher acceptance. It discards results still in the pipeline from before the job, compares each valid result against the target, and queues hits in a result FIFO for the host interface.

Parameters:
FIFO_DEPTH, 4, result FIFO entries (power of two, ≥2)
PIPE_SKIP, 2, acceptance edges whose registered result predates the first nonce of a job

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
job_valid  in  1  job offered
job_ready  out  1  scheduler can take a job (high only in IDLE)
job_midstate  in  256  first-chunk state for finisher X
job_tail  in  96  header tail for finisher Y
job_nonce_start  in  32  first nonce
job_nonce_end  in  32  last nonce (inclusive)
job_target  in  32  share threshold
abort  in  1  cancel current job
fin_X  out  256  finisher midstate, held from job register
fin_Y  out  96  finisher tail, held from job register
fin_nonce  out  32  current nonce
fin_accepted  in  1  finisher acceptance strobe (one cycle per 64)
fin_hash  in  256  finisher registered hash
fin_out_nonce  in  32  finisher registered nonce
result_valid  out  1  FIFO non-empty
result_ready  in  1  consumer pop
result_nonce  out  32  FIFO head nonce
result_word  out  32  FIFO head top hash word (byte-swapped)
busy  out  1  state RUN or DRAIN
job_done  out  1  one-cycle pulse at normal completion
overflow  out  1  sticky: a hit was dropped; cleared on job accept
hash_count  out  32  evaluated results this job; cleared on job accept

Behaviour:
- Reset (rst_n low, async): state IDLE; job_ready=1; busy=0; job_done=0; overflow=0; hash_count=0; FIFO empty (result_valid=0); fin_nonce=0; job registers 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: job_ready=1. On job_valid&&job_ready:
  - latch all job fields; fin_nonce=job_nonce_start; skip=PIPE_SKIP; overflow=0; hash_count=0.
  - next state RUN.
  - fin_accepted in IDLE is ignored.
- RUN, on fin_accepted:
  - if fin_nonce==end: go to DRAIN with drain=2; fin_nonce holds.
  - else fin_nonce increments mod 2^32.
  - Wrap is legal: start=FFFFFFFE, end=00000001 issues 4 nonces. start==end issues 1 nonce. start=end+1 issues 2^32 nonces.
- Result qualification: on each fin_accepted in RUN or DRAIN:
  - if skip>0, decrement skip and take no evaluation;
  - otherwise set eval_pending.
- Evaluation (the cycle after eval_pending is set; fin_hash and fin_out_nonce are stable then):
  - W = {fin_hash[231:224], fin_hash[239:232], fin_hash[247:240], fin_hash[255:248]}.
  - hash_count++ (saturates at FFFFFFFF).
  - hit iff W <= target. On a hit, push {fin_out_nonce, W}.
  - Full FIFO with result_ready low and result_valid high: entry dropped, overflow=1.
  - Full FIFO with a pop in the same cycle: push succeeds.
- DRAIN: each fin_accepted decrements drain and is qualified as above. After the second one, go to DONE once its evaluation completes. fin_X, fin_Y and fin_nonce stay held.
- DONE: job_done=1 for one cycle, then IDLE.
- abort (any state, priority over everything): next state IDLE; any pending evaluation is discarded; no job_done; FIFO contents kept; counters kept.
- job_valid outside IDLE is ignored.
- FIFO:
  - registered head; first-word latency 1 cycle after push.
  - Pop occurs on result_valid&&result_ready.
  - Order preserved; contents survive job boundaries; flushed only by reset.
- Latency: a nonce presented before acceptance edge k is evaluated in the cycle after edge k+2.
- Total job duration: (N+2) acceptance edges plus 2 cycles for N nonces.

Test Plan:
- Reset mid-RUN: assert rst_n=0 while FIFO holds 2 entries -> all outputs at reset values immediately; job_ready=1; result_valid=0.
- Job start=5, end=7, target=FFFFFFFF, model finisher (out_nonce lags 2 edges):
  - FIFO receives nonces 5,6,7 in order; hash_count=3;
  - job_done pulses once after the 5th accepted edge;
  - the first 2 edge results are not queued.
- Wrap job start=FFFFFFFE, end=00000001, target=0, model W=0 only for nonce 0 -> exactly one entry {00000000, 00000000}; hash_count=4.
- FIFO_DEPTH=4, result_ready=0, 6 hits -> 4 entries held, overflow=1. Next job accept clears overflow but keeps the 4 entries.
- Abort 3 cycles after the 3rd accepted edge of a 100-nonce job -> IDLE next cycle; no job_done; new job accepted the following cycle with fin_nonce=new start.
- Full FIFO, hit evaluation with simultaneous pop -> push succeeds; count stays 4; overflow remains 0.
